// File: rtl/fp_mul_pkg.sv
// Shared definitions for the shared floating-point multiplier scheduler.
// Contents:
//   FP_W          width of an IEEE-754 single-precision word
//   TAG_ID_W      width of the id field carried in the tracking pipeline,
//                 sized for the largest supported requester count (8)
//   fp32_t        raw single-precision bit pattern
//   tag_t         one tracking-pipeline stage: {vld, id}
//   sched_state_t scheduler state encoding
package fp_mul_pkg;

   localparam int FP_W     = 32;
   localparam int TAG_ID_W = 3;

   typedef logic [FP_W-1:0] fp32_t;

   typedef struct packed {
      logic                vld;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } sched_state_t;

endpackage

// File: rtl/fp_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter.
// The arbiter is purely combinational. Priority search starts at ptr_i and
// wraps around modulo N. The pointer register belongs to the instantiating
// block, so this arbiter can be reused in front of any shared unit.
// Ports:
//   req_i      N       request vector
//   ptr_i      ID_W    index where the priority search starts
//   grant_o    N       one-hot grant, all-zero when nothing is requested
//   grantId_o  ID_W    index of the granted requester
//   any_o      1       a grant was issued
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = 2
)(
   input  logic [N-1:0]    req_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [N-1:0]    grant_o,
   output logic [ID_W-1:0] grantId_o,
   output logic            any_o
);

   // Walk the requesters starting at the pointer. The first active request
   // found wins; later matches are masked off by any_o so the grant stays
   // one-hot.
   always_comb begin
      int idx;
      idx       = 0;
      grant_o   = '0;
      grantId_o = '0;
      any_o     = 1'b0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr_i) + off) % N;
         if (!any_o && req_i[idx]) begin
            any_o        = 1'b1;
            grant_o[idx] = 1'b1;
            grantId_o    = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Scheduler that shares one external FP multiplier between N_REQ requesters.
// Each cycle, at most one request is granted in round-robin order. The
// granted operands are driven to the multiplier. The requester id is then
// tracked through a MUL_LATENCY-deep tag pipeline, so the result can be
// routed back to the requester that issued it.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   req_valid   per-requester request; req_a/req_b carry operands packed [32*i+:32]
//   req_ready   one-hot grant
//   drain       stop granting new work, let in-flight work finish
//   mul_a/mul_b operands to the multiplier; held when nothing is granted
//   mul_result  multiplier result, valid MUL_LATENCY cycles after issue
//   rsp_valid   one-hot response strobe; rsp_result/rsp_id carry the data
//   busy        an operation is in flight
//   idle        scheduler is in the DRAINED state
//   op_count    completed-operation counter, wraps at 16 bits
module fp_mul_scheduler
   import fp_mul_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int MUL_LATENCY = 1,
   parameter int ID_W        = $clog2(N_REQ)
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_a,
   input  logic [32*N_REQ-1:0]  req_b,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 drain,
   output logic [31:0]          mul_a,
   output logic [31:0]          mul_b,
   input  logic [31:0]          mul_result,
   output logic [N_REQ-1:0]     rsp_valid,
   output logic [31:0]          rsp_result,
   output logic [ID_W-1:0]      rsp_id,
   output logic                 busy,
   output logic                 idle,
   output logic [15:0]          op_count
);

   sched_state_t     state_q;
   logic             idle_q;
   logic [ID_W-1:0]  rrPtr_q;
   logic [ID_W-1:0]  rrPtr_d;
   tag_t             tagPipe_q [MUL_LATENCY];
   tag_t             tagIn;
   tag_t             lastTag;
   fp32_t            heldA_q;
   fp32_t            heldB_q;
   fp32_t            selA;
   fp32_t            selB;
   logic [15:0]      opCount_q;
   logic [N_REQ-1:0] arbReq;
   logic [N_REQ-1:0] arbGrant;
   logic [ID_W-1:0]  arbId;
   logic             arbAny;
   logic             pipeBusy;

   // Requests are only visible to the arbiter while running. They are also
   // masked during reset, so req_ready reads zero as soon as reset asserts,
   // even if requesters are still holding their valids.
   assign arbReq = (state_q == RUN && !rst) ? req_valid : '0;

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) uArb (
      .req_i     (arbReq),
      .ptr_i     (rrPtr_q),
      .grant_o   (arbGrant),
      .grantId_o (arbId),
      .any_o     (arbAny)
   );

   assign req_ready = arbGrant;

   // Select the granted requester's operands. When there is no grant, the
   // multiplier inputs replay the last issued pair, so its input bus does
   // not toggle on idle cycles.
   always_comb begin
      selA  = req_a[int'(arbId)*FP_W +: FP_W];
      selB  = req_b[int'(arbId)*FP_W +: FP_W];
      mul_a = arbAny ? selA : heldA_q;
      mul_b = arbAny ? selB : heldB_q;
   end

   // The pointer moves to one past the granted requester, wrapping at
   // N_REQ. This lets the next search start just after the winner.
   always_comb begin
      rrPtr_d = rrPtr_q;
      if (arbAny) begin
         rrPtr_d = (int'(arbId) == N_REQ-1) ? '0 : arbId + 1'b1;
      end
   end

   // Register the pointer and the held operand pair. Both update only on
   // a handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rrPtr_q <= '0;
         heldA_q <= '0;
         heldB_q <= '0;
      end else if (arbAny) begin
         rrPtr_q <= rrPtr_d;
         heldA_q <= selA;
         heldB_q <= selB;
      end
   end

   // The tag pipeline mirrors the multiplier latency, so the last stage
   // lines up with mul_result. A reset clears every valid bit, which
   // silently drops the operations that were in flight.
   always_comb begin
      tagIn     = '0;
      tagIn.vld = arbAny;
      tagIn.id  = TAG_ID_W'(arbId);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < MUL_LATENCY; k++) begin
            tagPipe_q[k] <= '0;
         end
      end else begin
         tagPipe_q[0] <= tagIn;
         for (int k = 1; k < MUL_LATENCY; k++) begin
            tagPipe_q[k] <= tagPipe_q[k-1];
         end
      end
   end

   // Busy is any valid bit still travelling through the pipeline.
   always_comb begin
      pipeBusy = 1'b0;
      for (int k = 0; k < MUL_LATENCY; k++) begin
         pipeBusy = pipeBusy | tagPipe_q[k].vld;
      end
   end

   // The response side is driven straight from the last tag stage. The
   // result bus is zeroed when nothing is returning, so stale multiplier
   // output never appears on the response bus.
   always_comb begin
      lastTag    = tagPipe_q[MUL_LATENCY-1];
      rsp_valid  = lastTag.vld ? (N_REQ'(1) << lastTag.id) : '0;
      rsp_result = lastTag.vld ? mul_result : '0;
      rsp_id     = lastTag.vld ? ID_W'(lastTag.id) : '0;
   end

   // Count every returned result. The counter wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opCount_q <= '0;
      end else if (lastTag.vld) begin
         opCount_q <= opCount_q + 16'd1;
      end
   end

   // Drain control. The state is sampled before arbitration, so a drain
   // request raised in a cycle still lets that cycle's grant go through.
   // If drain drops while work is in flight, the scheduler returns straight
   // to RUN; that check takes priority over reaching DRAINED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         idle_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (drain) begin
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (!drain) begin
                  state_q <= RUN;
               end else if (!pipeBusy) begin
                  state_q <= DRAINED;
                  idle_q  <= 1'b1;
               end
            end
            DRAINED: begin
               if (!drain) begin
                  state_q <= RUN;
                  idle_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= RUN;
               idle_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = pipeBusy;
   assign idle     = idle_q;
   assign op_count = opCount_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed self-checking bench for fp_mul_scheduler with four requesters and
// a one-cycle multiplier. A registered behavioural FP multiplier stands in
// for the external FPMultiplier. Inputs are driven on the falling edge, and
// outputs are sampled shortly after that, well away from the rising edge.
module tb_fp_mul_scheduler;

   localparam int N   = 4;
   localparam int LAT = 1;
   localparam int IDW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  reqValid;
   logic [32*N-1:0] reqA;
   logic [32*N-1:0] reqB;
   logic [N-1:0]  reqReady;
   logic          drain;
   logic [31:0]   mulA;
   logic [31:0]   mulB;
   logic [31:0]   mulResult = '0;
   logic [N-1:0]  rspValid;
   logic [31:0]   rspResult;
   logic [IDW-1:0] rspId;
   logic          busy;
   logic          idle;
   logic [15:0]   opCount;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp2 [4];
   logic [31:0] vecA [4];
   logic [31:0] vecB [4];
   logic [31:0] vecR [4];

   fp_mul_scheduler #(
      .N_REQ       (N),
      .MUL_LATENCY (LAT),
      .ID_W        (IDW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (reqValid),
      .req_a      (reqA),
      .req_b      (reqB),
      .req_ready  (reqReady),
      .drain      (drain),
      .mul_a      (mulA),
      .mul_b      (mulB),
      .mul_result (mulResult),
      .rsp_valid  (rspValid),
      .rsp_result (rspResult),
      .rsp_id     (rspId),
      .busy       (busy),
      .idle       (idle),
      .op_count   (opCount)
   );

   always #5 clk = ~clk;

   // Behavioural single-precision multiply for normal numbers and zero.
   // It truncates instead of rounding, which is exact for the operand
   // pairs used here.
   function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      logic [22:0] m;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'b0};
      p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 1;
      end else begin
         m = p[45:23];
      end
      return {s, e[7:0], m};
   endfunction

   // External multiplier model with a one-cycle registered result.
   always @(posedge clk) mulResult <= fpMul(mulA, mulB);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] a, input logic [31:0] b);
      reqA[32*idx +: 32] = a;
      reqB[32*idx +: 32] = b;
      reqValid[idx]      = 1'b1;
   endtask

   initial begin
      exp2[0] = 32'h42908000; exp2[1] = 32'h42908000;
      exp2[2] = 32'hC2908000; exp2[3] = 32'h42DC8000;
      vecA[0] = 32'h41280000; vecB[0] = 32'h41280000; vecR[0] = 32'h42DC8000;
      vecA[1] = 32'h40D80000; vecB[1] = 32'h40500000; vecR[1] = 32'h41AF8000;
      vecA[2] = 32'h00000000; vecB[2] = 32'h41080000; vecR[2] = 32'h00000000;
      vecA[3] = 32'h3F800000; vecB[3] = 32'h41080000; vecR[3] = 32'h41080000;

      rst      = 1'b1;
      reqValid = '0;
      reqA     = '0;
      reqB     = '0;
      drain    = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst ready",   {28'b0, reqReady}, 32'h0);
      checkOutput("rst rspValid", {28'b0, rspValid}, 32'h0);
      checkOutput("rst mulA",    mulA, 32'h0);
      checkOutput("rst busy",    {31'b0, busy}, 32'h0);
      checkOutput("rst idle",    {31'b0, idle}, 32'h0);
      checkOutput("rst opCount", {16'b0, opCount}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single op: 8.5 * 8.5 from requester 0
      applyStimulus(0, 32'h41080000, 32'h41080000);
      #1;
      checkOutput("t1 ready", {28'b0, reqReady}, 32'h1);
      checkOutput("t1 mulA",  mulA, 32'h41080000);
      @(negedge clk);
      reqValid = '0;
      #1;
      checkOutput("t1 rspValid", {28'b0, rspValid}, 32'h1);
      checkOutput("t1 result",   rspResult, 32'h42908000);
      checkOutput("t1 rspId",    {30'b0, rspId}, 32'h0);
      checkOutput("t1 busy",     {31'b0, busy}, 32'h1);
      @(negedge clk);
      checkOutput("t1 opCount",  {16'b0, opCount}, 32'h1);
      checkOutput("t1 rspDone",  {28'b0, rspValid}, 32'h0);
      checkOutput("t1 mulHold",  mulA, 32'h41080000);

      // All four requesters valid straight out of reset
      rst = 1'b1;
      #1;
      rst = 1'b0;
      applyStimulus(0, 32'h41080000, 32'h41080000);
      applyStimulus(1, 32'hC1080000, 32'hC1080000);
      applyStimulus(2, 32'h41080000, 32'hC1080000);
      applyStimulus(3, 32'h41280000, 32'h41280000);
      for (int g = 0; g < 4; g++) begin
         #1;
         checkOutput($sformatf("t2 grant%0d", g), {28'b0, reqReady}, 32'h1 << g);
         if (g > 0) begin
            checkOutput($sformatf("t2 rspId%0d", g-1), {30'b0, rspId}, g-1);
            checkOutput($sformatf("t2 result%0d", g-1), rspResult, exp2[g-1]);
         end
         @(negedge clk);
         reqValid[g] = 1'b0;
      end
      #1;
      checkOutput("t2 rspId3",  {30'b0, rspId}, 32'h3);
      checkOutput("t2 result3", rspResult, exp2[3]);
      @(negedge clk);
      checkOutput("t2 opCount", {16'b0, opCount}, 32'h4);

      // Fairness: requesters 1 and 3 alternate, then pointer wraps to 0
      applyStimulus(1, 32'h3F800000, 32'h41080000);
      applyStimulus(3, 32'h3F800000, 32'h41080000);
      for (int g = 0; g < 4; g++) begin
         #1;
         checkOutput($sformatf("t3 grant%0d", g), {28'b0, reqReady}, (g % 2 == 0) ? 32'h2 : 32'h8);
         @(negedge clk);
      end
      applyStimulus(0, 32'h3F800000, 32'h41080000);
      #1;
      checkOutput("t3 wrap", {28'b0, reqReady}, 32'h1);
      @(negedge clk);
      reqValid = '0;
      @(negedge clk);

      // Operand values through requester 2
      for (int v = 0; v < 4; v++) begin
         applyStimulus(2, vecA[v], vecB[v]);
         #1;
         checkOutput($sformatf("t4 ready%0d", v), {28'b0, reqReady}, 32'h4);
         @(negedge clk);
         reqValid = '0;
         #1;
         checkOutput($sformatf("t4 result%0d", v), rspResult, vecR[v]);
         @(negedge clk);
      end

      // Drain asserted during a granted cycle (pointer is 3 here)
      applyStimulus(1, 32'h41280000, 32'h41280000);
      drain = 1'b1;
      #1;
      checkOutput("t5 grant", {28'b0, reqReady}, 32'h2);
      @(negedge clk);
      reqValid = 4'b0001;
      #1;
      checkOutput("t5 blocked1", {28'b0, reqReady}, 32'h0);
      checkOutput("t5 rspValid", {28'b0, rspValid}, 32'h2);
      checkOutput("t5 result",   rspResult, 32'h42DC8000);
      @(negedge clk);
      checkOutput("t5 blocked2", {28'b0, reqReady}, 32'h0);
      checkOutput("t5 busy",     {31'b0, busy}, 32'h0);
      checkOutput("t5 notIdle",  {31'b0, idle}, 32'h0);
      @(negedge clk);
      checkOutput("t5 idle",     {31'b0, idle}, 32'h1);
      checkOutput("t5 blocked3", {28'b0, reqReady}, 32'h0);
      drain    = 1'b0;
      reqValid = 4'b1001;
      #1;
      checkOutput("t5 stillIdle", {28'b0, reqReady}, 32'h0);
      @(negedge clk);
      checkOutput("t5 resume", {28'b0, reqReady}, 32'h8);
      @(negedge clk);
      reqValid[3] = 1'b0;
      #1;
      checkOutput("t5 next", {28'b0, reqReady}, 32'h1);
      @(negedge clk);
      reqValid = '0;
      @(negedge clk);

      // Async reset with two operations in flight (pointer is 1 here)
      applyStimulus(0, 32'h41080000, 32'h41080000);
      applyStimulus(1, 32'h41080000, 32'h41080000);
      #1;
      checkOutput("t6 grant1", {28'b0, reqReady}, 32'h2);
      @(negedge clk);
      reqValid[1] = 1'b0;
      #1;
      checkOutput("t6 grant0", {28'b0, reqReady}, 32'h1);
      checkOutput("t6 rsp1",   {28'b0, rspValid}, 32'h2);
      rst = 1'b1;
      #1;
      checkOutput("t6 ready",    {28'b0, reqReady}, 32'h0);
      checkOutput("t6 rspValid", {28'b0, rspValid}, 32'h0);
      checkOutput("t6 result",   rspResult, 32'h0);
      checkOutput("t6 mulA",     mulA, 32'h0);
      checkOutput("t6 mulB",     mulB, 32'h0);
      checkOutput("t6 busy",     {31'b0, busy}, 32'h0);
      checkOutput("t6 opCount",  {16'b0, opCount}, 32'h0);
      @(negedge clk);
      rst      = 1'b0;
      reqValid = '0;
      #1;
      checkOutput("t6 noStale1", {28'b0, rspValid}, 32'h0);
      @(negedge clk);
      checkOutput("t6 noStale2", {28'b0, rspValid}, 32'h0);
      checkOutput("t6 cnt",      {16'b0, opCount}, 32'h0);
      reqValid = 4'b0011;
      #1;
      checkOutput("t6 ptr0", {28'b0, reqReady}, 32'h1);
      @(negedge clk);
      reqValid = '0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
